// File: rtl/ram_1kx8.sv
// ram_1kx8 - single-port synchronous scratch RAM with a post-reset clear engine.
//
// After rst is released the clear engine walks every word, writing zero one
// location per cycle. Only once that sweep has finished does init_done go high
// and the RAM start honouring user reads and writes. Reads go through a
// registered output, and a same-address read/write collision is write-first.
//
// Optional build macro: RAM_PARITY_EN
//   When it is defined, each word carries an even-parity bit and an extra
//   output port, parity_error, is added. parity_error is registered together
//   with data_out.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_CLEAR | sweeping zeros into mem[r_ptr]; user accesses are dropped
// S_READY | sweep finished; one user access is served per cycle

module ram_1kx8 #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
`ifdef RAM_PARITY_EN
    output logic                  parity_error,
`endif
    output logic                  init_done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

`ifdef RAM_PARITY_EN
    // The parity bit sits above the data bits in each stored word.
    localparam int WORD_WIDTH = DATA_WIDTH + 1;
`else
    localparam int WORD_WIDTH = DATA_WIDTH;
`endif

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    logic [WORD_WIDTH-1:0] r_mem [DEPTH];

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_init_done;
`ifdef RAM_PARITY_EN
    logic                  r_parity_error;
`endif

    logic                  w_last_ptr;
    logic                  w_user_write;
    logic [WORD_WIDTH-1:0] w_wr_word;
    logic [WORD_WIDTH-1:0] w_rd_word;

    // The sweep ends at the top of the address space. Natural truncation sends
    // the pointer back to 0 there, and the pointer is unused after that point.
    assign w_last_ptr   = &r_ptr;
    assign w_user_write = (r_state == S_READY) && write_enable;
    assign w_rd_word    = r_mem[address];

`ifdef RAM_PARITY_EN
    assign w_wr_word = {^data_in, data_in};
`else
    assign w_wr_word = data_in;
`endif

    // Storage array. It has no reset: the clear sweep is what initialises it.
    // Nothing is written while rst is asserted, so the state of the array
    // depends only on the sweep and on user writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_CLEAR) begin
                r_mem[r_ptr] <= '0;
            end else if (w_user_write) begin
                r_mem[address] <= w_wr_word;
            end
        end
    end

    // Sequencer and registered outputs: this block runs the clear sweep, and
    // after it completes it drives the write-first read path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_CLEAR;
            r_ptr          <= '0;
            r_data_out     <= '0;
            r_init_done    <= 1'b0;
`ifdef RAM_PARITY_EN
            r_parity_error <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_data_out     <= '0;
`ifdef RAM_PARITY_EN
                    r_parity_error <= 1'b0;
`endif
                    r_ptr          <= r_ptr + ADDR_WIDTH'(1);
                    if (w_last_ptr) begin
                        r_state     <= S_READY;
                        r_init_done <= 1'b1;
                    end
                end
                S_READY: begin
                    if (write_enable) begin
                        // Write-first: the incoming word bypasses the array.
                        r_data_out     <= data_in;
`ifdef RAM_PARITY_EN
                        r_parity_error <= 1'b0;
`endif
                    end else begin
                        r_data_out     <= w_rd_word[DATA_WIDTH-1:0];
`ifdef RAM_PARITY_EN
                        r_parity_error <= w_rd_word[DATA_WIDTH] != ^w_rd_word[DATA_WIDTH-1:0];
`endif
                    end
                end
                default: begin
                    r_state <= S_CLEAR;
                    r_ptr   <= '0;
                end
            endcase
        end
    end

    assign data_out     = r_data_out;
    assign init_done    = r_init_done;
`ifdef RAM_PARITY_EN
    assign parity_error = r_parity_error;
`endif

endmodule

// File: tb/tb_ram_1kx8.sv
// tb_ram_1kx8 - directed and randomised checks for ram_1kx8 against an
// array-based reference memory. Define RAM_PARITY_EN to exercise the parity build.

module tb_ram_1kx8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       write_enable = 1'b0;
    logic [9:0] address = '0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       init_done;
`ifdef RAM_PARITY_EN
    logic       parity_error;
`endif

    int         tests = 0;
    int         fails = 0;
    int         par_bad = 0;
    logic [7:0] ref_mem [1024];
    logic       ref_ready = 1'b0;
    logic [7:0] exp_out = '0;
    int         sweep_len;
    int         sweep_bad;

    ram_1kx8 dut (
        .clk          (clk),
        .rst          (rst),
        .write_enable (write_enable),
        .address      (address),
        .data_in      (data_in),
        .data_out     (data_out),
`ifdef RAM_PARITY_EN
        .parity_error (parity_error),
`endif
        .init_done    (init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One access: drive at the falling edge, let the DUT clock it, and update
    // the reference model (write-first), then return at the next falling edge.
    task automatic access(input logic we, input logic [9:0] a, input logic [7:0] d);
        write_enable = we;
        address      = a;
        data_in      = d;
        @(posedge clk);
        if (ref_ready) begin
            exp_out = we ? d : ref_mem[a];
            if (we) ref_mem[a] = d;
        end else begin
            exp_out = 8'h00;
        end
        @(negedge clk);
`ifdef RAM_PARITY_EN
        if (parity_error !== 1'b0) par_bad++;
`endif
    endtask

    // Apply traffic while the sweep runs, including writes of 0xFF to
    // address 10, and count the rising edges until init_done is seen high.
    task automatic wait_sweep(output int n, output int bad);
        n   = -1;
        bad = 0;
        for (int c = 1; c <= 1100; c++) begin
            if (c >= 3 && c <= 5) begin
                write_enable = 1'b1;
                address      = 10'd10;
                data_in      = 8'hFF;
            end else begin
                write_enable = 1'($urandom_range(0, 1));
                address      = 10'($urandom);
                data_in      = 8'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            if (data_out !== 8'h00) bad++;
`ifdef RAM_PARITY_EN
            if (parity_error !== 1'b0) par_bad++;
`endif
            if (init_done === 1'b1) begin
                n = c;
                break;
            end
        end
        write_enable = 1'b0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        ref_ready = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_dout", 32'(data_out), 32'h0);
        check("reset_init", 32'(init_done), 32'h0);

        rst = 1'b0;
        wait_sweep(sweep_len, sweep_bad);
        check("sweep_len", 32'(sweep_len), 32'd1024);
        check("sweep_dout_zero", 32'(sweep_bad), 32'd0);

        access(1'b0, 10'd0, 8'h00);    check("rd0_clear", 32'(data_out), 32'h00);
        access(1'b0, 10'd55, 8'h00);   check("rd55_clear", 32'(data_out), 32'h00);
        access(1'b0, 10'd1023, 8'h00); check("rd1023_clear", 32'(data_out), 32'h00);
        access(1'b0, 10'd10, 8'h00);   check("rd10_dropped", 32'(data_out), 32'h00);

        access(1'b1, 10'd55, 8'h56);   check("wr55_first", 32'(data_out), 32'h56);
        access(1'b0, 10'd55, 8'h00);   check("rd55_hold_a", 32'(data_out), 32'h56);
        access(1'b0, 10'd55, 8'h00);   check("rd55_hold_b", 32'(data_out), 32'h56);

        access(1'b1, 10'd66, 8'h36);   check("wr66_first", 32'(data_out), 32'h36);
        access(1'b0, 10'd55, 8'h00);   check("rd55_after66", 32'(data_out), 32'h56);

        access(1'b1, 10'd1023, 8'hA5); check("wr1023", 32'(data_out), 32'hA5);
        access(1'b1, 10'd0, 8'h5A);    check("wr0", 32'(data_out), 32'h5A);
        access(1'b0, 10'd1023, 8'h00); check("rd1023", 32'(data_out), 32'hA5);
        access(1'b0, 10'd0, 8'h00);    check("rd0", 32'(data_out), 32'h5A);

        for (int k = 0; k < 400; k++) begin
            logic       we;
            logic [9:0] a;
            logic [7:0] d;
            we = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 2) == 0) ? 10'($urandom_range(0, 7)) : 10'($urandom);
            d  = 8'($urandom);
            access(we, a, d);
            check("random", 32'(data_out), 32'(exp_out));
        end

        access(1'b0, 10'd55, 8'h00);   check("rd55_pre_rst", 32'(data_out), 32'(ref_mem[55]));
        #2 rst = 1'b1;
        ref_ready = 1'b0;
        #1;
        check("async_rst_dout", 32'(data_out), 32'h0);
        check("async_rst_init", 32'(init_done), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        repeat (500) @(negedge clk);
        check("mid_sweep_init", 32'(init_done), 32'h0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_dout", 32'(data_out), 32'h0);
        check("mid_rst_init", 32'(init_done), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_sweep(sweep_len, sweep_bad);
        check("resweep_len", 32'(sweep_len), 32'd1024);
        check("resweep_dout_zero", 32'(sweep_bad), 32'd0);
        access(1'b0, 10'd55, 8'h00);   check("rd55_recleared", 32'(data_out), 32'h00);
        access(1'b0, 10'd1023, 8'h00); check("rd1023_recleared", 32'(data_out), 32'h00);
        access(1'b0, 10'd66, 8'h00);   check("rd66_recleared", 32'(data_out), 32'h00);

`ifdef RAM_PARITY_EN
        check("parity_quiet", 32'(par_bad), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_1kx8.md
Name: ram_1kx8

Overview:
- Single-port synchronous static RAM, 1024 words x 8 bits by default, used as general-purpose on-chip scratch storage.
- One shared address bus serves both reads and writes.
- Data is written on a clock edge when write enable is high, and read through a registered output.
- After reset, a built-in clear engine zeroes every location before the RAM accepts accesses.

Parameters:
- ADDR_WIDTH, 10, address bits; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 8, bits per word.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- write_enable  input  1  when high at a rising edge (and init_done=1), writes data_in to mem[address].
- address  input  ADDR_WIDTH  word address for both read and write.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  registered read data.
- init_done  output  1  high once the post-reset clear sweep has finished; accesses are honoured only while high.

Behaviour:
- Reset (rst=1, asynchronous):
  - data_out=0, init_done=0, clear pointer=0.
  - Memory contents are not directly reset.
- Clear sweep:
  - Starts on the first rising edge after rst deasserts.
  - Writes 0 to location ptr and increments ptr, one word per cycle, ptr = 0..DEPTH-1.
  - After writing DEPTH-1, init_done goes high on the next edge and stays high until the next reset. A full sweep takes DEPTH cycles (1024 by default).
  - During the sweep: write_enable is ignored (user writes are dropped, not queued) and data_out is held at 0.
- Reset mid-sweep: pointer returns to 0; the sweep restarts from address 0 after release.
- Write, when init_done=1 and write_enable=1 at a rising edge: mem[address] <= data_in.
- Read, when init_done=1: every rising edge loads data_out with mem[address]. Latency is 1 cycle from address presentation.
  - data_out updates every cycle, whether or not a write occurs.
- Read/write collision (same edge, same address): write-first. data_out shows the new data_in on that edge.
- Address range:
  - All ADDR_WIDTH-bit values are valid, 0..DEPTH-1.
  - No wrap logic is required beyond natural truncation.
- Unknown or uninitialised reads cannot occur after the sweep; every location holds 0 until written.
- No handshake: the block accepts one access per cycle with no backpressure once init_done=1.

Optional Feature:
- Macro RAM_PARITY_EN.
- When defined:
  - Each word stores an extra even-parity bit computed from data_in on write; the clear sweep stores 0 with parity 0.
  - Output port parity_error (1 bit) is added. It is registered alongside data_out and goes high for one cycle when the stored parity does not match the read word.
  - parity_error resets to 0 and is 0 during the sweep.
- When undefined: no parity storage and no parity_error port. Behaviour is otherwise identical.

Test Plan:
- Reset, then release: init_done low for exactly 1024 cycles, then high. Reading addresses 0, 55, 1023 returns 0x00.
- After init, address=55, data_in=0x56, write_enable=1 for one edge: data_out=0x56 on that same edge (write-first). With write_enable=0 it remains 0x56 on later edges.
- Write 0x36 to address 66, then set address=55 with write_enable=0: data_out=0x36 while at 66, then 0x56 one cycle after switching to 55. Location 55 is unchanged.
- write_enable=1 with data_in=0xFF to address 10 during the sweep: write is ignored, data_out stays 0. After init_done, reading address 10 returns 0x00.
- Assert rst at sweep cycle 500 for 2 cycles: data_out=0 and init_done=0 immediately (asynchronous). The sweep restarts and init_done rises 1024 cycles after release.
- Boundary: write 0xA5 to 1023 and 0x5A to 0, then read both: 0xA5 and 0x5A, with no aliasing. With RAM_PARITY_EN, parity_error stays 0 throughout.
